// File: rtl/coeff_replay_buffer.sv
// Coefficient replay buffer: linear write fill, non-destructive 1-cycle reads, rewind/clear.
// Optional sticky overflow/underflow flags under macro COEFF_RB_ERR_FLAGS_EN.
module coeff_replay_buffer #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       ADDR_W  = 5,
    parameter logic [DATA_W-1:0] MARKER  = 32'h7F90_0000,
    parameter bit                WRAP_RD = 1'b0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en_i,
    input  logic              replay_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              start_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W-1:0] rd_ptr_o
`ifdef COEFF_RB_ERR_FLAGS_EN
    ,
    output logic              err_ovf_o,
    output logic              err_udf_o
`endif
);

    localparam int unsigned   DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] OneCnt   = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              wrap_done_q, wrap_done_d;
    logic              is_marker, wr_acc, rd_acc, rd_last;

    assign is_marker = (data_i == MARKER);
    assign full_o    = (count_q == DepthCnt);
    assign empty_o   = (count_q == '0);
    assign wr_acc    = wr_en_i & ~full_o & ~clear_i & ~is_marker;
    // Read compares against the pre-write count, so a same-cycle write never satisfies it.
    assign rd_acc    = rd_en_i & ~replay_i & ~clear_i & (rd_ptr_q < count_q);
    assign rd_last   = (rd_ptr_q == count_q - OneCnt);

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        start_d     = wr_en_i & is_marker;
        wrap_done_d = 1'b0;
        if (clear_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) begin
                count_d = count_q + OneCnt;
            end
            if (replay_i) begin
                rd_ptr_d = '0;
            end else if (rd_acc) begin
                data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
                valid_d = 1'b1;
                if (WRAP_RD && rd_last) begin
                    rd_ptr_d    = '0;
                    wrap_done_d = 1'b1;
                end else begin
                    rd_ptr_d = rd_ptr_q + OneCnt;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            wrap_done_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            wrap_done_q <= wrap_done_d;
        end
    end

    // Storage needs no reset; count_q alone defines which slots are live.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[count_q[ADDR_W-1:0]] <= data_i;
        end
    end

    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign start_o  = start_q;
    assign done_o   = WRAP_RD ? wrap_done_q : ((rd_ptr_q == count_q) & ~empty_o);
    assign count_o  = count_q;
    assign wr_ptr_o = count_q[ADDR_W-1:0];
    assign rd_ptr_o = rd_ptr_q[ADDR_W-1:0];

`ifdef COEFF_RB_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clear_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en_i & full_o & ~is_marker) begin
                ovf_q <= 1'b1;
            end
            if (rd_en_i & (rd_ptr_q == count_q) & (~WRAP_RD | empty_o)) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign err_ovf_o = ovf_q;
    assign err_udf_o = udf_q;
`endif

endmodule

// File: tb/tb_coeff_replay_buffer.sv
// Bench for coeff_replay_buffer: a saturating (u0) and a wrapping (u1) instance share stimulus,
// checked every cycle against a queue-based reference model plus literal spot checks.
module tb_coeff_replay_buffer;

    localparam logic [31:0] MARK = 32'h7F90_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, replay = 1'b0, clear = 1'b0;
    logic [31:0] data_in = '0;

    logic [31:0] o0_data, o1_data;
    logic        o0_valid, o0_full, o0_empty, o0_start, o0_done;
    logic        o1_valid, o1_full, o1_empty, o1_start, o1_done;
    logic [5:0]  o0_count, o1_count;
    logic [4:0]  o0_wr, o0_rd, o1_wr, o1_rd;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stored words as a queue, one read index per instance.
    logic [31:0] mq[$];
    int          rdm[2];
    logic        ev[2];
    logic [31:0] ed[2];
    logic        ewd[2];
    logic        es;

    always #5 clk = ~clk;

    coeff_replay_buffer #(.WRAP_RD(1'b0)) u0 (
        .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .data_i(data_in), .rd_en_i(rd_en),
        .replay_i(replay), .clear_i(clear), .data_o(o0_data), .valid_o(o0_valid),
        .full_o(o0_full), .empty_o(o0_empty), .start_o(o0_start), .done_o(o0_done),
        .count_o(o0_count), .wr_ptr_o(o0_wr), .rd_ptr_o(o0_rd)
    );

    coeff_replay_buffer #(.WRAP_RD(1'b1)) u1 (
        .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .data_i(data_in), .rd_en_i(rd_en),
        .replay_i(replay), .clear_i(clear), .data_o(o1_data), .valid_o(o1_valid),
        .full_o(o1_full), .empty_o(o1_empty), .start_o(o1_start), .done_o(o1_done),
        .count_o(o1_count), .wr_ptr_o(o1_wr), .rd_ptr_o(o1_rd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        es = 1'b0;
        for (int w = 0; w < 2; w++) begin
            rdm[w] = 0;
            ev[w]  = 1'b0;
            ed[w]  = '0;
            ewd[w] = 1'b0;
        end
    endtask

    task automatic model_step();
        int n;
        n  = mq.size();
        es = wr_en && (data_in == MARK);
        for (int w = 0; w < 2; w++) begin
            ewd[w] = 1'b0;
            ev[w]  = 1'b0;
            if (clear || replay) begin
                rdm[w] = 0;
            end else if (rd_en && rdm[w] < n) begin
                ed[w] = mq[rdm[w]];
                ev[w] = 1'b1;
                if (w == 1 && rdm[w] == n - 1) begin
                    rdm[w] = 0;
                    ewd[w] = 1'b1;
                end else begin
                    rdm[w]++;
                end
            end
        end
        if (clear) mq.delete();
        else if (wr_en && data_in != MARK && n < 32) mq.push_back(data_in);
    endtask

    task automatic cmp_inst(input int w, input logic [31:0] d, input logic v, input logic dn,
                            input logic st, input logic [5:0] cnt, input logic em,
                            input logic fl, input logic [4:0] wp, input logic [4:0] rp);
        int   n;
        logic edone;
        n     = mq.size();
        edone = (w == 0) ? (rdm[0] == n && n != 0) : ewd[1];
        check($sformatf("u%0d.valid", w), {31'd0, v}, {31'd0, ev[w]});
        check($sformatf("u%0d.data", w), d, ed[w]);
        check($sformatf("u%0d.done", w), {31'd0, dn}, {31'd0, edone});
        check($sformatf("u%0d.start", w), {31'd0, st}, {31'd0, es});
        check($sformatf("u%0d.count", w), {26'd0, cnt}, n);
        check($sformatf("u%0d.empty", w), {31'd0, em}, {31'd0, n == 0});
        check($sformatf("u%0d.full", w), {31'd0, fl}, {31'd0, n == 32});
        check($sformatf("u%0d.wr_ptr", w), {27'd0, wp}, n % 32);
        check($sformatf("u%0d.rd_ptr", w), {27'd0, rp}, rdm[w] % 32);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, o0_data, o0_valid, o0_done, o0_start, o0_count, o0_empty, o0_full,
                 o0_wr, o0_rd);
        cmp_inst(1, o1_data, o1_valid, o1_done, o1_start, o1_count, o1_empty, o1_full,
                 o1_wr, o1_rd);
    end

    task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic rp,
                       input logic cl);
        wr_en = w; data_in = d; rd_en = r; replay = rp; clear = cl;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    logic [31:0] vals[4];
    logic        rw, rr, rrp, rcl;
    logic [31:0] rd_val;

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset.count", {26'd0, o0_count}, 32'd0);
        check("reset.empty", {31'd0, o0_empty}, 32'd1);
        check("reset.data", o0_data, 32'd0);
        rstn = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Three-float write then read-back.
        cyc(1, 32'h3F80_0000, 0, 0, 0);
        cyc(1, 32'h4000_0000, 0, 0, 0);
        cyc(1, 32'h4040_0000, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("seq.d0", o0_data, 32'h3F80_0000);
        cyc(0, 0, 1, 0, 0);
        check("seq.d1", o0_data, 32'h4000_0000);
        cyc(0, 0, 1, 0, 0);
        check("seq.d2", o0_data, 32'h4040_0000);
        check("seq.count", {26'd0, o0_count}, 32'd3);
        check("seq.done", {31'd0, o0_done}, 32'd1);

        // Fill to capacity, then one more write is dropped.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++) cyc(1, 32'h1000 + i, 0, 0, 0);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
        check("fill.full", {31'd0, o0_full}, 32'd1);
        check("fill.count", {26'd0, o0_count}, 32'd32);

        // Replay after partial read-out.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            vals[i] = 32'hA000_0000 + i;
            cyc(1, vals[i], 0, 0, 0);
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        check("replay.valid", {31'd0, o0_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0);
            check($sformatf("replay.d%0d", i), o0_data, vals[i]);
        end

        // Wrapping instance: 3 entries, 7 reads.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, vals[i], 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 0, 1, 0, 0);
            check($sformatf("wrap.d%0d", k), o1_data, vals[(k - 1) % 3]);
            check($sformatf("wrap.done%0d", k), {31'd0, o1_done}, {31'd0, k == 3 || k == 6});
        end

        // Marker while empty.
        cyc(0, 0, 0, 0, 1);
        cyc(1, MARK, 0, 0, 0);
        check("mark.start", {31'd0, o0_start}, 32'd1);
        check("mark.count", {26'd0, o0_count}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("mark.pulse", {31'd0, o0_start}, 32'd0);

        // Clear beats a same-cycle write and read.
        for (int i = 0; i < 5; i++) cyc(1, 32'h55 + i, 0, 0, 0);
        cyc(1, 32'h77, 1, 0, 1);
        check("clr.count", {26'd0, o0_count}, 32'd0);
        check("clr.valid", {31'd0, o0_valid}, 32'd0);

        // Asynchronous reset in the middle of a read.
        cyc(1, 32'h11, 0, 0, 0);
        cyc(1, 32'h22, 0, 0, 0);
        wr_en = 0; rd_en = 1;
        #2 rstn = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst.valid", {31'd0, o0_valid}, 32'd0);
        check("rst.count", {26'd0, o0_count}, 32'd0);
        check("rst.data", o0_data, 32'd0);
        rd_en = 0;
        rstn  = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check("rst.novalid", {31'd0, o0_valid}, 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rw     = ($urandom_range(0, 99) < 55);
            rd_val = ($urandom_range(0, 19) == 0) ? MARK : $urandom;
            rr     = ($urandom_range(0, 99) < 60);
            rrp    = ($urandom_range(0, 29) == 0);
            rcl    = ($urandom_range(0, 119) == 0);
            cyc(rw, rd_val, rr, rrp, rcl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
